gc_poll_tx: RTL and testbench

Upstream stage of the controller reader. Periodically transmits the 24-bit GameCube poll command plus stop bit on the single-wire data line (open-drain), then asserts `ready` for a fixed response window so the reader counts edges and samples buttons. Lives in the same fabric clock domain as the reader; its `ready` feeds the reader's `ready` input directly.

---
 rtl/gc_pkg.sv | 27 ++
 rtl/gc_bit_timer.sv | 50 +++++
 rtl/gc_poll_tx.sv | 179 +++++++++++++++++
 tb/tb_gc_poll_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// rtl/gc_pkg.sv - shared encodings and constants for the GameCube poll path
//
// Purpose: FSM state encoding, the poll command word and the slot counts
// that define the single-wire bit encoding. Imported by the poll transmitter
// and its bit timer.
package gc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TX_BIT  = 2'd1,
        ST_TX_STOP = 2'd2,
        ST_RESP    = 2'd3
    } gc_state_e;

    // Poll command; bit 0 is OR-ed with the rumble request at transaction start.
    localparam logic [23:0] GC_POLL_CMD = 24'h400300;

    localparam int SLOTS_PER_BIT  = 4;
    localparam int ZERO_LOW_SLOTS = 3;
    localparam int ONE_LOW_SLOTS  = 1;

    // Number of leading low slots used to encode one data bit.
    function automatic logic [1:0] low_slots(input logic bit_val);
        return bit_val ? 2'(ONE_LOW_SLOTS) : 2'(ZERO_LOW_SLOTS);
    endfunction

endpackage

// File: rtl/gc_bit_timer.sv
// rtl/gc_bit_timer.sv - tick/slot counter generating slot and bit boundaries
//
// Purpose: divides the fabric clock into 1 us slots and groups them into
// SLOTS_PER_BIT-slot bit cells. Counters sit at zero while run_i is low, so
// the first active cycle is always tick 0 of slot 0.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   run_i        count while high, hold cleared while low
//   slot_o       current slot index within the bit cell
//   slot_done_o  high on the last tick of a slot
//   bit_done_o   high on the last tick of the last slot of a bit cell
module gc_bit_timer
    import gc_pkg::*;
#(
    parameter int US_TICKS = 100
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    output logic [1:0] slot_o,
    output logic       slot_done_o,
    output logic       bit_done_o
);

    localparam int TW = (US_TICKS > 1) ? $clog2(US_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(US_TICKS - 1);
    localparam logic [1:0]    SLOT_LAST = 2'(SLOTS_PER_BIT - 1);

    logic [TW-1:0] tick_q;
    logic [1:0]    slot_q;

    assign slot_o      = slot_q;
    assign slot_done_o = run_i && (tick_q == TICK_LAST);
    assign bit_done_o  = slot_done_o && (slot_q == SLOT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || !run_i) begin
            tick_q <= '0;
            slot_q <= '0;
        end else if (slot_done_o) begin
            tick_q <= '0;
            // Four slots per bit: the 2-bit slot index wraps back to 0 by itself.
            slot_q <= slot_q + 2'd1;
        end else begin
            tick_q <= tick_q + TW'(1);
        end
    end

endmodule

// File: rtl/gc_poll_tx.sv
// rtl/gc_poll_tx.sv - periodic GameCube poll transmitter with response window
//
// Purpose: every POLL_INTERVAL cycles sends the 24-bit poll command plus a
// stop bit on the open-drain data line, then holds ready for RESP_TICKS
// cycles so the downstream reader can capture the controller response.
// Ports:
//   PCLK        fabric clock
//   PRESERN     synchronous active-high reset
//   enable      1 = new polls may start
//   rumble      command bit 0, sampled at transaction start
//   data_in     raw line level (asynchronous)
//   data_oe     1 = pull line low, 0 = release
//   ready       response window active
//   busy        transaction in progress
//   poll_done   one-cycle pulse when the response window closes
//   line_fault  sticky: line was low when a poll was due
module gc_poll_tx
    import gc_pkg::*;
#(
    parameter int US_TICKS      = 100,
    parameter int POLL_INTERVAL = 1666666,
    parameter int RESP_TICKS    = 40000,
    parameter int CMD_BITS      = 24
) (
    input  logic PCLK,
    input  logic PRESERN,
    input  logic enable,
    input  logic rumble,
    input  logic data_in,
    output logic data_oe,
    output logic ready,
    output logic busy,
    output logic poll_done,
    output logic line_fault
);

    localparam int IW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int BW = (CMD_BITS > 1) ? $clog2(CMD_BITS) : 1;
    localparam int RW = (RESP_TICKS > 1) ? $clog2(RESP_TICKS) : 1;

    localparam logic [IW-1:0] INT_LAST  = IW'(POLL_INTERVAL - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CMD_BITS - 1);
    localparam logic [RW-1:0] RESP_LAST = RW'(RESP_TICKS - 1);

    logic                din_meta_q;
    logic                din_s_q;
    gc_state_e           state_q, state_d;
    logic [CMD_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]       bit_idx_q, bit_idx_d;
    logic [RW-1:0]       resp_cnt_q, resp_cnt_d;
    logic [IW-1:0]       int_cnt_q, int_cnt_d;
    logic                oe_d, ready_d, done_d, fault_d;

    logic       due;
    logic       timer_run;
    logic [1:0] slot;
    logic       slot_done;
    logic       bit_done;
    logic [1:0] cur_low;

    assign due       = (int_cnt_q == INT_LAST);
    assign timer_run = (state_q == ST_TX_BIT) || (state_q == ST_TX_STOP);
    assign cur_low   = low_slots(shift_q[CMD_BITS-1]);

    gc_bit_timer #(
        .US_TICKS (US_TICKS)
    ) u_bit_timer (
        .clk_i       (PCLK),
        .rst_i       (PRESERN),
        .run_i       (timer_run),
        .slot_o      (slot),
        .slot_done_o (slot_done),
        .bit_done_o  (bit_done)
    );

    // Next-state logic. Outputs are derived from the next state so that the
    // registered data_oe/ready line up with the state they belong to.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        resp_cnt_d = resp_cnt_q;
        oe_d       = 1'b0;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        fault_d    = line_fault;
        int_cnt_d  = int_cnt_q;

        // Saturating interval counter; holds while polling is disabled.
        if (enable && !due) begin
            int_cnt_d = int_cnt_q + IW'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (due && enable) begin
                    if (din_s_q) begin
                        state_d   = ST_TX_BIT;
                        shift_d   = CMD_BITS'(GC_POLL_CMD) | CMD_BITS'(rumble);
                        bit_idx_d = '0;
                        int_cnt_d = '0;
                        oe_d      = 1'b1;
                    end else begin
                        // Someone else holds the line low; wait for release.
                        fault_d = 1'b1;
                    end
                end
            end
            ST_TX_BIT: begin
                if (bit_done) begin
                    // Every bit cell and the stop bit start with a low slot.
                    oe_d = 1'b1;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = ST_TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                        shift_d   = shift_q << 1;
                    end
                end else if (slot_done) begin
                    oe_d = (slot + 2'd1) < cur_low;
                end else begin
                    oe_d = slot < cur_low;
                end
            end
            ST_TX_STOP: begin
                if (slot_done) begin
                    state_d    = ST_RESP;
                    resp_cnt_d = '0;
                    ready_d    = 1'b1;
                end else begin
                    oe_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_cnt_q == RESP_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    resp_cnt_d = resp_cnt_q + RW'(1);
                    ready_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESERN) begin
            din_meta_q <= 1'b0;
            din_s_q    <= 1'b0;
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            resp_cnt_q <= '0;
            int_cnt_q  <= '0;
            data_oe    <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            poll_done  <= 1'b0;
            line_fault <= 1'b0;
        end else begin
            din_meta_q <= data_in;
            din_s_q    <= din_meta_q;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            resp_cnt_q <= resp_cnt_d;
            int_cnt_q  <= int_cnt_d;
            data_oe    <= oe_d;
            ready      <= ready_d;
            busy       <= (state_d != ST_IDLE);
            poll_done  <= done_d;
            line_fault <= fault_d;
        end
    end

endmodule

// File: tb/tb_gc_poll_tx.sv
// tb/tb_gc_poll_tx.sv - scoreboard bench for the GameCube poll transmitter
module tb_gc_poll_tx;

    localparam int US   = 4;
    localparam int PI   = 2000;
    localparam int PI_B = 500;
    localparam int RT   = 300;
    localparam int CB   = 24;
    localparam int TXC  = (CB * 4 + 1) * US;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst, enable, rumble, data_in;
    logic data_oe, ready, busy, poll_done, line_fault;
    logic rst_b, en_b, rum_b, din_b;
    logic oe_b, rdy_b, busy_b, pd_b, lf_b;

    gc_poll_tx #(.US_TICKS(US), .POLL_INTERVAL(PI), .RESP_TICKS(RT), .CMD_BITS(CB)) dut (
        .PCLK(clk), .PRESERN(rst), .enable(enable), .rumble(rumble), .data_in(data_in),
        .data_oe(data_oe), .ready(ready), .busy(busy), .poll_done(poll_done),
        .line_fault(line_fault)
    );

    gc_poll_tx #(.US_TICKS(US), .POLL_INTERVAL(PI_B), .RESP_TICKS(RT), .CMD_BITS(CB)) dut_b (
        .PCLK(clk), .PRESERN(rst_b), .enable(en_b), .rumble(rum_b), .data_in(din_b),
        .data_oe(oe_b), .ready(rdy_b), .busy(busy_b), .poll_done(pd_b),
        .line_fault(lf_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [23:0] cmd;
        int          lo;
        int          hi;
        bit          abort;
    } exp_t;

    exp_t sbq[$];
    int   n_started = 0;
    int   n_done    = 0;
    int   nb_b      = 0;

    function automatic logic [23:0] model_cmd(input logic r);
        return 24'h400300 | {23'd0, r};
    endfunction

    task automatic push(input logic [23:0] cmd, input int lo, input int hi, input bit ab);
        exp_t e;
        e.cmd = cmd; e.lo = lo; e.hi = hi; e.abort = ab;
        sbq.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_start(output int s);
        logic pb;
        pb = busy;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (data_oe && !pb && !rst) begin
                s = cyc;
                return;
            end
            pb = busy;
        end
        check("start_timeout", 0, 1);
        s = cyc;
    endtask

    // Monitor: decodes each transaction from the line and checks it against the scoreboard.
    initial begin : mon_a
        logic        prev_b;
        logic        smp [TXC];
        exp_t        e;
        int          s, rl;
        bit          ab, shape_ok, bad;
        logic [23:0] got;
        prev_b = 1'b1;
        forever begin
            @(negedge clk);
            if (rst || !(data_oe && !prev_b)) begin
                prev_b = busy;
                continue;
            end
            s = cyc;
            n_started++;
            if (sbq.size() == 0) begin
                check($sformatf("unexpected_poll_at_%0d", s), 1, 0);
                for (int i = 0; i < TXC + RT + 10 && busy; i++) @(negedge clk);
                prev_b = busy;
                continue;
            end
            e = sbq.pop_front();
            check($sformatf("start_cycle_%0d_in_%0d_to_%0d", s, e.lo, e.hi),
                  (s >= e.lo && s <= e.hi), 1);
            smp[0] = data_oe;
            ab = 0;
            for (int k = 1; k < TXC; k++) begin
                @(negedge clk);
                if (rst) begin
                    ab = 1;
                    break;
                end
                smp[k] = data_oe;
            end
            check("abort_expected", ab, e.abort);
            if (ab) begin
                @(negedge clk);
                check("reset_data_oe", data_oe, 0);
                check("reset_ready", ready, 0);
                check("reset_busy", busy, 0);
                prev_b = busy;
                continue;
            end
            got = '0;
            shape_ok = 1;
            for (int b = 0; b < CB; b++) begin
                int ones;
                bit seen0;
                ones = 0;
                seen0 = 0;
                for (int j = 0; j < 4 * US; j++) begin
                    if (smp[b * 4 * US + j]) begin
                        ones++;
                        if (seen0) shape_ok = 0;
                    end else begin
                        seen0 = 1;
                    end
                end
                if (ones == US) got = {got[22:0], 1'b1};
                else if (ones == 3 * US) got = {got[22:0], 1'b0};
                else begin
                    shape_ok = 0;
                    got = {got[22:0], 1'b0};
                end
            end
            for (int j = 0; j < US; j++) if (!smp[CB * 4 * US + j]) shape_ok = 0;
            check("cmd", got, e.cmd);
            check("bit_shape_and_stop", shape_ok, 1);
            @(negedge clk);
            rl = 0;
            bad = 0;
            while (ready && rl < RT + 20) begin
                rl++;
                if (data_oe || !busy) bad = 1;
                @(negedge clk);
            end
            check("ready_len", rl, RT);
            check("resp_line_released_busy", bad, 0);
            check("poll_done_pulse", poll_done, 1);
            check("idle_after_resp", busy, 0);
            @(negedge clk);
            check("poll_done_single", poll_done, 0);
            n_done++;
            prev_b = busy;
        end
    end

    // Short-interval instance: the next poll must follow poll_done immediately.
    initial begin : mon_b
        forever begin
            @(negedge clk);
            if (!rst_b && pd_b && nb_b < 5) begin
                check("b_idle_at_poll_done", busy_b, 0);
                check("b_ready_low_at_poll_done", rdy_b, 0);
                @(negedge clk);
                check("b_oe_next_cycle", oe_b, 1);
                nb_b++;
            end
        end
    end

    initial begin : stim
        int s, d, x;
        logic r;
        rst = 1; enable = 0; rumble = 0; data_in = 1;
        rst_b = 1; en_b = 0; rum_b = 0; din_b = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_data_oe", data_oe, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_poll_done", poll_done, 0);
        check("rst_line_fault", line_fault, 0);

        @(posedge clk); #1;
        rst = 0; enable = 1; rumble = 0;
        rst_b = 0; en_b = 1; rum_b = 1'($urandom_range(0, 1));
        push(model_cmd(0), cyc + PI, cyc + PI, 0);
        wait_start(s);

        @(posedge clk); #1;
        r = 1'($urandom_range(0, 1));
        rumble = r;
        push(model_cmd(r), s + PI, s + PI, 0);
        wait_start(s);

        @(posedge clk); #1;
        rumble = 1;
        push(model_cmd(1), s + PI, s + PI, 0);
        wait_start(s);
        wait_cyc(s + 10 * 4 * US + 2);
        rumble = 0;
        push(model_cmd(0), s + PI, s + PI, 0);
        wait_start(s);

        wait_cyc(s + 1000);
        check("fault_clear_before", line_fault, 0);
        r = 1'($urandom_range(0, 1));
        rumble = r;
        data_in = 0;
        wait_cyc(s + PI + 50);
        check("fault_set_when_due_low", line_fault, 1);
        check("oe_held_while_low", data_oe, 0);
        data_in = 1;
        push(model_cmd(r), cyc + 1, cyc + 3, 0);
        wait_start(s);
        check("fault_sticky", line_fault, 1);

        push(model_cmd(r), s + PI, s + PI, 0);
        wait_start(s);
        wait_cyc(s + 5 * 4 * US + 2);
        enable = 0;
        d = cyc;
        wait_cyc(s + TXC + RT + 5000);
        check("starts_while_disabled", n_started, 6);
        check("done_while_disabled", n_done, 6);

        enable = 1;
        x = cyc;
        push(model_cmd(r), x + PI - (d - s), x + PI - (d - s), 1);
        wait_start(s);
        wait_cyc(s + CB * 4 * US + 1);
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        push(model_cmd(r), cyc + PI, cyc + PI, 0);
        wait_start(s);
        wait_cyc(s + TXC + RT + 10);

        check("total_starts", n_started, 8);
        check("total_done", n_done, 7);
        check("scoreboard_empty", sbq.size(), 0);
        check("b_backtoback_seen", nb_b, 5);
        check("b_no_fault", lf_b, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
